// File: rtl/fifo_64i_32o_prefetch.sv
// Show-ahead FIFO that takes 64-bit words and returns them as two 32-bit words, low half first.
// Latency: 1 cycle write-to-read; rd_vld/wr_vld are registered from the next-state level counts.
// Backpressure: wr_vld drops when every entry is allocated; rd_en is ignored while rd_vld is low.
//
// Ports:
//   clk, rst          single rising-edge clock, asynchronous active-high reset
//   wr_en/wr_vld      write handshake; a write happens on wr_en && wr_vld
//   wr_data           64-bit input word, [31:0] emitted first
//   rd_en/rd_vld      read handshake; a pop happens on rd_en && rd_vld
//   rd_data           32-bit show-ahead output, valid while rd_vld=1
//   wr_level          occupied 64-bit entries (0..DEPTH)
//   rd_level          available 32-bit words (0..2*DEPTH)
module fifo_64i_32o_prefetch #(
  parameter int DEPTH_WIDTH   = 3,
  parameter int WR_DATA_WIDTH = 64,
  parameter int RD_DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  output logic                     wr_vld,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     rd_en,
  output logic                     rd_vld,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic [DEPTH_WIDTH:0]     wr_level,
  output logic [DEPTH_WIDTH+1:0]   rd_level
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_WIDTH:0]   WL_ONE     = 1;
  localparam logic [DEPTH_WIDTH:0]   WL_FULL    = DEPTH;
  localparam logic [DEPTH_WIDTH+1:0] RL_ONE     = 1;
  localparam logic [DEPTH_WIDTH+1:0] RL_TWO     = 2;
  localparam logic [DEPTH_WIDTH+1:0] RL_ZERO    = 0;

  logic [WR_DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_WIDTH-1:0]   wptr;
  logic [DEPTH_WIDTH-1:0]   rptr;
  logic                     hsel;

  logic                     wr_fire;
  logic                     rd_fire;
  logic                     entry_free;
  logic [DEPTH_WIDTH:0]     wr_level_next;
  logic [DEPTH_WIDTH+1:0]   rd_level_next;
  logic [WR_DATA_WIDTH-1:0] head;

  assign wr_fire    = wr_en && wr_vld;
  assign rd_fire    = rd_en && rd_vld;
  // Only popping the high half retires the 64-bit entry.
  assign entry_free = rd_fire && hsel;

  always_comb begin
    wr_level_next = wr_level;
    if (wr_fire && !entry_free) begin
      wr_level_next = wr_level + WL_ONE;
    end else if (!wr_fire && entry_free) begin
      wr_level_next = wr_level - WL_ONE;
    end
  end

  always_comb begin
    rd_level_next = rd_level;
    case ({wr_fire, rd_fire})
      2'b10:   rd_level_next = rd_level + RL_TWO;
      2'b01:   rd_level_next = rd_level - RL_ONE;
      2'b11:   rd_level_next = rd_level + RL_ONE;
      default: rd_level_next = rd_level;
    endcase
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      hsel     <= 1'b0;
      wr_level <= '0;
      rd_level <= '0;
      wr_vld   <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_fire) begin
        hsel <= !hsel;
        if (hsel) begin
          rptr <= rptr + PTR_ONE;
        end
      end
      wr_level <= wr_level_next;
      rd_level <= rd_level_next;
      // Flags come from the next-state counts so they are glitch-free
      // registers; a pop that frees the last slot reopens writes one edge later.
      wr_vld   <= (wr_level_next != WL_FULL);
      rd_vld   <= (rd_level_next != RL_ZERO);
    end
  end

  assign head    = mem[rptr];
  assign rd_data = hsel ? head[WR_DATA_WIDTH-1:RD_DATA_WIDTH] : head[RD_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_64i_32o_prefetch.sv
module tb_fifo_64i_32o_prefetch;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        wr_vld;
  logic [63:0] wr_data;
  logic        rd_en;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic [3:0]  wr_level;
  logic [4:0]  rd_level;

  int n_checks;
  int n_fail;

  fifo_64i_32o_prefetch #(
    .DEPTH_WIDTH   (3),
    .WR_DATA_WIDTH (64),
    .RD_DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .wr_level (wr_level),
    .rd_level (rd_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #3;
    n_checks++;
    if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL reset_wr_vld got=%b exp=0", wr_vld); end
    n_checks++;
    if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL release_wr_vld got=%b exp=1", wr_vld); end
    n_checks++;
    if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL release_rd_vld got=%b exp=0", rd_vld); end
    n_checks++;
    if (wr_level !== 4'd0 || rd_level !== 5'd0) begin
      n_fail++; $display("FAIL release_levels got=%0d/%0d exp=0/0", wr_level, rd_level);
    end
  endtask

  task automatic test_single_word();
    wr_en = 1'b1; wr_data = 64'h89ABCDEF_01234567;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== 32'h01234567) begin
      n_fail++; $display("FAIL single_low got vld=%b data=%h exp vld=1 data=01234567", rd_vld, rd_data);
    end
    n_checks++;
    if (rd_level !== 5'd2 || wr_level !== 4'd1) begin
      n_fail++; $display("FAIL single_levels got=%0d/%0d exp=1/2", wr_level, rd_level);
    end
    rd_en = 1'b1;
    step();
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== 32'h89ABCDEF || rd_level !== 5'd1) begin
      n_fail++; $display("FAIL single_high got vld=%b data=%h rl=%0d exp 1/89abcdef/1", rd_vld, rd_data, rd_level);
    end
    step();
    rd_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || wr_level !== 4'd0 || rd_level !== 5'd0) begin
      n_fail++; $display("FAIL single_drain got vld=%b wl=%0d rl=%0d exp 0/0/0", rd_vld, wr_level, rd_level);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_w;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
      step();
    end
    n_checks++;
    if (wr_vld !== 1'b0 || wr_level !== 4'd8 || rd_level !== 5'd16) begin
      n_fail++; $display("FAIL fill_full got wr_vld=%b wl=%0d rl=%0d exp 0/8/16", wr_vld, wr_level, rd_level);
    end
    wr_data = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (wr_level !== 4'd8 || rd_level !== 5'd16) begin
      n_fail++; $display("FAIL fill_overflow got wl=%0d rl=%0d exp 8/16", wr_level, rd_level);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (wr_vld !== 1'b0 || rd_level !== 5'd15 || rd_data !== 32'hB000_0000) begin
      n_fail++; $display("FAIL fill_pop_low got wr_vld=%b rl=%0d data=%h exp 0/15/b0000000", wr_vld, rd_level, rd_data);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (wr_vld !== 1'b1 || wr_level !== 4'd7 || rd_level !== 5'd14) begin
      n_fail++; $display("FAIL fill_pop_high got wr_vld=%b wl=%0d rl=%0d exp 1/7/14", wr_vld, wr_level, rd_level);
    end
    // Remaining halves must be words 1..7 in order, nothing from the rejected write.
    rd_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      exp_w = ((k % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) | 32'(1 + k / 2);
      n_checks++;
      if (rd_vld !== 1'b1 || rd_data !== exp_w) begin
        n_fail++; $display("FAIL fill_drain[%0d] got vld=%b data=%h exp %h", k, rd_vld, rd_data, exp_w);
      end
      step();
    end
    rd_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || wr_level !== 4'd0) begin
      n_fail++; $display("FAIL fill_empty got vld=%b wl=%0d exp 0/0", rd_vld, wr_level);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] sb[$];
    logic [31:0] exp_w;
    int wcount;
    int got;
    int gaps;
    bit started;
    wcount = 0; got = 0; gaps = 0; started = 0;
    rd_en = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      if (rd_vld === 1'b1) begin
        started = 1;
        exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
        got++;
        n_checks++;
        if (rd_data !== exp_w) begin
          n_fail++; $display("FAIL stream[%0d] got=%h exp=%h", got - 1, rd_data, exp_w);
        end
      end else if (started) begin
        gaps++;
      end
      wr_en = 1'b0;
      if ((c % 2) == 0 && wcount < 50 && wr_vld === 1'b1) begin
        wr_en = 1'b1;
        wr_data = {32'hD000_0000 | 32'(wcount), 32'hC000_0000 | 32'(wcount)};
        sb.push_back(wr_data[31:0]);
        sb.push_back(wr_data[63:32]);
        wcount++;
      end
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (got !== 100 || gaps !== 0) begin
      n_fail++; $display("FAIL stream_count got words=%0d gaps=%0d exp 100/0", got, gaps);
    end
    n_checks++;
    if (rd_vld !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL stream_tail got vld=%b leftover=%0d exp 0/0", rd_vld, sb.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = {32'hF100_0000 | 32'(i), 32'hE100_0000 | 32'(i)};
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    // Full with hsel=1: pop of high half plus a write that must be rejected.
    wr_en = 1'b1; wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (wr_level !== 4'd7 || rd_level !== 5'd14 || wr_vld !== 1'b1) begin
      n_fail++; $display("FAIL simul_full got wl=%0d rl=%0d wr_vld=%b exp 7/14/1", wr_level, rd_level, wr_vld);
    end
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) step();
    rd_en = 1'b0;
    n_checks++;
    if (wr_level !== 4'd3 || rd_level !== 5'd6) begin
      n_fail++; $display("FAIL simul_pre got wl=%0d rl=%0d exp 3/6", wr_level, rd_level);
    end
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 64'h7777_8888_5555_6666;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (wr_level !== 4'd4 || rd_level !== 5'd7) begin
      n_fail++; $display("FAIL simul_low_write got wl=%0d rl=%0d exp 4/7", wr_level, rd_level);
    end
    exp_q = '{32'hF100_0005, 32'hE100_0006, 32'hF100_0006, 32'hE100_0007,
              32'hF100_0007, 32'h5555_6666, 32'h7777_8888};
    for (int k = 0; k < 7; k++) begin
      exp_w = exp_q[k];
      n_checks++;
      if (rd_vld !== 1'b1 || rd_data !== exp_w) begin
        n_fail++; $display("FAIL simul_drain[%0d] got vld=%b data=%h exp %h", k, rd_vld, rd_data, exp_w);
      end
      step();
    end
    rd_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || wr_level !== 4'd0 || rd_level !== 5'd0) begin
      n_fail++; $display("FAIL simul_empty got vld=%b wl=%0d rl=%0d exp 0/0/0", rd_vld, wr_level, rd_level);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = {32'h9900_0000 | 32'(i), 32'h8800_0000 | 32'(i)};
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (wr_level !== 4'd5 || rd_level !== 5'd9) begin
      n_fail++; $display("FAIL mid_pre got wl=%0d rl=%0d exp 5/9", wr_level, rd_level);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (wr_level !== 4'd0 || rd_level !== 5'd0 || rd_vld !== 1'b0 || wr_vld !== 1'b0) begin
      n_fail++; $display("FAIL mid_async got wl=%0d rl=%0d rd_vld=%b wr_vld=%b exp 0/0/0/0",
                         wr_level, rd_level, rd_vld, wr_vld);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (wr_vld !== 1'b1 || rd_vld !== 1'b0) begin
      n_fail++; $display("FAIL mid_release got wr_vld=%b rd_vld=%b exp 1/0", wr_vld, rd_vld);
    end
    wr_en = 1'b1; wr_data = 64'h4444_3333_2222_1111;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== 32'h2222_1111 || rd_level !== 5'd2 || wr_level !== 4'd1) begin
      n_fail++; $display("FAIL mid_first got vld=%b data=%h rl=%0d wl=%0d exp 1/22221111/2/1",
                         rd_vld, rd_data, rd_level, wr_level);
    end
    rd_en = 1'b1;
    step();
    n_checks++;
    if (rd_data !== 32'h4444_3333) begin
      n_fail++; $display("FAIL mid_second got=%h exp=44443333", rd_data);
    end
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    test_reset();
    test_single_word();
    test_fill();
    test_streaming();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_64i_32o_prefetch.md
Name: fifo_64i_32o_prefetch

Overview:
Single-clock show-ahead FIFO and width downsizer. It accepts 64-bit words and delivers them as two 32-bit words, low half first. It sits on the return path of the 32-to-64 packing FIFO. Result/feature-map words produced 64 bits wide by the convolution datapath are narrowed back to the 32-bit stream interface. It uses the same wr_en/wr_vld and rd_en/rd_vld handshake as the team's prefetch FIFOs.

Parameters:
DEPTH_WIDTH, 3, log2 of buffer depth in 64-bit entries (DEPTH = 2**DEPTH_WIDTH, default 8); legal values 1..8.
WR_DATA_WIDTH, 64, input word width; fixed at 2*RD_DATA_WIDTH.
RD_DATA_WIDTH, 32, output word width.

Ports:
clk  input  1  single clock for all logic, rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  write request; a write occurs when wr_en && wr_vld at a clk edge.
wr_vld  output  1  write side can accept a word (registered, not full).
wr_data  input  64  write data; [31:0] is emitted first, [63:32] second.
rd_en  input  1  read acknowledge; a pop occurs when rd_en && rd_vld at a clk edge.
rd_vld  output  1  rd_data holds a valid 32-bit word (registered).
rd_data  output  32  show-ahead read data; valid whenever rd_vld=1.
wr_level  output  DEPTH_WIDTH+1  occupied 64-bit entries, 0..DEPTH.
rd_level  output  DEPTH_WIDTH+2  available 32-bit words, 0..2*DEPTH.

Behaviour:
- Storage: DEPTH x 64 array with asynchronous read. wptr and rptr are DEPTH_WIDTH bits and wrap naturally from DEPTH-1 to 0. A half-select bit hsel picks the output half.
- rd_data = hsel ? mem[rptr][63:32] : mem[rptr][31:0]. It is combinational from registered state.
- Write (wr_en && wr_vld): mem[wptr] <= wr_data; wptr++; wr_level +1; rd_level +2.
- Pop (rd_en && rd_vld):
  - If hsel=0: hsel <= 1; rd_level -1; rptr and wr_level unchanged.
  - If hsel=1: hsel <= 0; rptr++; wr_level -1 (entry freed); rd_level -1.
- Simultaneous write and pop in the same cycle: both take effect. Net wr_level = +1 or 0 (depending on whether the pop frees an entry). Net rd_level = +1.
- Flags are registered from next-state counts:
  - wr_vld <= (wr_level_next != DEPTH)
  - rd_vld <= (rd_level_next != 0)
- Latency: a word written at edge N gives rd_vld=1 and the low half on rd_data after edge N. This holds when the FIFO was empty: 1-cycle write-to-read.
- Full: wr_vld=0. wr_en is ignored with no pointer or memory change. A pop of the high half while full raises wr_vld after that edge; there is no same-cycle bypass.
- Empty: rd_vld=0. rd_en is ignored and rd_data is don't-care. No underflow of any counter.
- Partially consumed entry: after a low-half pop, the entry stays allocated until the high half is popped. wr_level counts it.
- Reset (asynchronous, any time including mid-transfer):
  - wptr, rptr, hsel, wr_level, rd_level = 0.
  - wr_vld = 0, rd_vld = 0.
  - Stored data is discarded; memory contents are not cleared.
- First edge after rst deasserts: wr_vld <= 1, rd_vld stays 0.
- No X propagation: rd_vld and wr_vld never go X after reset, regardless of wr_data/rd_en values.

Test Plan:
1. Reset then idle: rst pulse -> wr_vld=0, rd_vld=0 during reset; wr_vld=1 one edge after release; wr_level=0, rd_level=0.
2. Single word: write 64'h89ABCDEF_01234567 -> next cycle rd_vld=1, rd_data=32'h01234567, rd_level=2. Pop -> rd_data=32'h89ABCDEF, rd_level=1. Pop -> rd_vld=0, wr_level=0.
3. Fill: write 8 words with rd_en=0 -> wr_vld=0 after the 8th, wr_level=8, rd_level=16. A 9th wr_en is ignored. Pop one half -> wr_vld stays 0. Pop second half -> wr_vld=1, wr_level=7.
4. Streaming: wr_en every other cycle and rd_en=1 continuously -> 32-bit output stream is gap-free in order L0,H0,L1,H1,…. 100 words are checked against the scoreboard with no loss or duplication across pointer wrap.
5. Simultaneous write and pop at wr_level=8 (high-half pop) -> the write is rejected (wr_vld was 0) and the pop succeeds. Then at wr_level=3 with a low-half pop plus a write -> wr_level=4, rd_level +1.
6. Reset mid-operation: assert rst with 5 entries queued and hsel=1 -> all levels 0 and rd_vld=0 immediately (asynchronous). After release, the first write's low half appears with no stale data.
